// File: rtl/riscv_mem_arbiter_if.sv
// Purpose : bundles the fetch, data and memory-side signals of the shared memory arbiter.
// Latency : n/a (wires only).
// Backpressure: none here; imem_ready/imem_rvalid carry the memory-side stall.
// Ports   : fetch req/addr/rdata/valid, data req/we/be/addr/wdata/rdata/valid,
//           memory req/we/be/addr/wdata/ready/rvalid/rdata, hazard-unit stall.
// Modports: master = the arbiter (it masters the memory bus); slave = core + memory.
interface riscv_mem_arbiter_if #(
    parameter int MP_DATA_WIDTH = 32,
    parameter int MP_ADDR_WIDTH = 32
);
    // instruction-fetch requester
    logic                     iif_req;
    logic [MP_ADDR_WIDTH-1:0] iif_addr;
    logic [MP_DATA_WIDTH-1:0] oif_rdata;
    logic                     oif_valid;
    // data requester
    logic                     id_req;
    logic                     id_we;
    logic [1:0]               id_be;
    logic [MP_ADDR_WIDTH-1:0] id_addr;
    logic [MP_DATA_WIDTH-1:0] id_wdata;
    logic [MP_DATA_WIDTH-1:0] od_rdata;
    logic                     od_valid;
    // shared memory port
    logic                     omem_req;
    logic                     omem_we;
    logic [1:0]               omem_be;
    logic [MP_ADDR_WIDTH-1:0] omem_addr;
    logic [MP_DATA_WIDTH-1:0] omem_wdata;
    logic                     imem_ready;
    logic                     imem_rvalid;
    logic [MP_DATA_WIDTH-1:0] imem_rdata;
    // hazard unit
    logic                     ostall;

    modport master (
        input  iif_req, iif_addr,
        output oif_rdata, oif_valid,
        input  id_req, id_we, id_be, id_addr, id_wdata,
        output od_rdata, od_valid,
        output omem_req, omem_we, omem_be, omem_addr, omem_wdata,
        input  imem_ready, imem_rvalid, imem_rdata,
        output ostall
    );

    modport slave (
        output iif_req, iif_addr,
        input  oif_rdata, oif_valid,
        output id_req, id_we, id_be, id_addr, id_wdata,
        input  od_rdata, od_valid,
        input  omem_req, omem_we, omem_be, omem_addr, omem_wdata,
        output imem_ready, imem_rvalid, imem_rdata,
        input  ostall
    );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Purpose : shares one memory port between instruction fetch and data access, one transaction at a time.
// Latency : 4 cycles per transaction minimum (IDLE grant, ISSUE, WAIT, DONE pulse).
// Backpressure: imem_ready low holds ISSUE, imem_rvalid low holds WAIT; ostall tells the pipeline to wait.
// Ports   : iclk, irst (async active-high), bus (riscv_mem_arbiter_if.master) carrying
//           both requesters, the memory port and the hazard-unit stall.
module riscv_mem_arbiter #(
    parameter int MP_DATA_WIDTH   = 32,
    parameter int MP_ADDR_WIDTH   = 32,
    parameter int MP_MAX_DATA_RUN = 4
) (
    input  logic                   iclk,
    input  logic                   irst,
    riscv_mem_arbiter_if.master    bus
);

    localparam int RW = $clog2(MP_MAX_DATA_RUN + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(MP_MAX_DATA_RUN);
    localparam logic [1:0]    BE_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic                     owner_data_q, owner_data_d;   // 1 = data port owns the transaction
    logic [RW-1:0]            run_cnt_q, run_cnt_d;
    logic                     omem_req_q, omem_req_d;
    logic                     omem_we_q, omem_we_d;
    logic [1:0]               omem_be_q, omem_be_d;
    logic [MP_ADDR_WIDTH-1:0] omem_addr_q, omem_addr_d;
    logic [MP_DATA_WIDTH-1:0] omem_wdata_q, omem_wdata_d;
    logic [MP_DATA_WIDTH-1:0] oif_rdata_q, oif_rdata_d;
    logic [MP_DATA_WIDTH-1:0] od_rdata_q, od_rdata_d;
    logic                     oif_valid_q, oif_valid_d;
    logic                     od_valid_q, od_valid_d;

    logic any_req;
    logic fetch_wins;

    assign any_req = bus.iif_req | bus.id_req;
    // Data normally wins; a pending fetch takes the port once data has had its full run.
    assign fetch_wins = bus.iif_req & (~bus.id_req | (run_cnt_q == RUN_MAX));

    // ---------------- state register ----------------
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_q      <= S_IDLE;
            owner_data_q <= 1'b0;
            run_cnt_q    <= '0;
            omem_req_q   <= 1'b0;
            omem_we_q    <= 1'b0;
            omem_be_q    <= 2'b00;
            omem_addr_q  <= '0;
            omem_wdata_q <= '0;
            oif_rdata_q  <= '0;
            od_rdata_q   <= '0;
            oif_valid_q  <= 1'b0;
            od_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_data_q <= owner_data_d;
            run_cnt_q    <= run_cnt_d;
            omem_req_q   <= omem_req_d;
            omem_we_q    <= omem_we_d;
            omem_be_q    <= omem_be_d;
            omem_addr_q  <= omem_addr_d;
            omem_wdata_q <= omem_wdata_d;
            oif_rdata_q  <= oif_rdata_d;
            od_rdata_q   <= od_rdata_d;
            oif_valid_q  <= oif_valid_d;
            od_valid_q   <= od_valid_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req)         state_d = S_ISSUE;
            S_ISSUE: if (bus.imem_ready)  state_d = S_WAIT;
            S_WAIT:  if (bus.imem_rvalid) state_d = S_DONE;
            S_DONE:                       state_d = S_IDLE;
            default:                      state_d = S_IDLE;
        endcase
    end

    // ---------------- output / datapath logic ----------------
    always_comb begin
        owner_data_d = owner_data_q;
        run_cnt_d    = run_cnt_q;
        omem_req_d   = omem_req_q;
        omem_we_d    = omem_we_q;
        omem_be_d    = omem_be_q;
        omem_addr_d  = omem_addr_q;
        omem_wdata_d = omem_wdata_q;
        oif_rdata_d  = oif_rdata_q;
        od_rdata_d   = od_rdata_q;
        oif_valid_d  = 1'b0;
        od_valid_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    omem_req_d = 1'b1;
                    if (fetch_wins) begin
                        owner_data_d = 1'b0;
                        run_cnt_d    = '0;
                        omem_we_d    = 1'b0;
                        omem_be_d    = BE_WORD;
                        omem_addr_d  = bus.iif_addr;
                        // wdata is don't-care for a fetch; leave the register alone
                    end else begin
                        owner_data_d = 1'b1;
                        // the run only counts data grants that kept a fetch waiting
                        if (!bus.iif_req)
                            run_cnt_d = '0;
                        else if (run_cnt_q != RUN_MAX)
                            run_cnt_d = run_cnt_q + 1'b1;
                        omem_we_d    = bus.id_we;
                        omem_be_d    = bus.id_be;
                        omem_addr_d  = bus.id_addr;
                        omem_wdata_d = bus.id_wdata;
                    end
                end
            end
            S_ISSUE: begin
                if (bus.imem_ready)
                    omem_req_d = 1'b0;
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    if (owner_data_q) begin
                        od_valid_d = 1'b1;
                        if (!omem_we_q)
                            od_rdata_d = bus.imem_rdata;
                    end else begin
                        oif_valid_d = 1'b1;
                        oif_rdata_d = bus.imem_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.omem_req   = omem_req_q;
    assign bus.omem_we    = omem_we_q;
    assign bus.omem_be    = omem_be_q;
    assign bus.omem_addr  = omem_addr_q;
    assign bus.omem_wdata = omem_wdata_q;
    assign bus.oif_rdata  = oif_rdata_q;
    assign bus.od_rdata   = od_rdata_q;
    assign bus.oif_valid  = oif_valid_q;
    assign bus.od_valid   = od_valid_q;
    assign bus.ostall     = (bus.iif_req & ~oif_valid_q) | (bus.id_req & ~od_valid_q);

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Purpose : directed self-checking bench for riscv_mem_arbiter.
// Latency : drives inputs and samples outputs 1 time unit after each rising edge.
// Backpressure: the bench plays the memory, delaying imem_ready/imem_rvalid per step.
module tb_riscv_mem_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    riscv_mem_arbiter_if #(.MP_DATA_WIDTH(32), .MP_ADDR_WIDTH(32)) bus ();

    riscv_mem_arbiter #(
        .MP_DATA_WIDTH  (32),
        .MP_ADDR_WIDTH  (32),
        .MP_MAX_DATA_RUN(4)
    ) dut (
        .iclk(clk),
        .irst(rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_omem_req"},   bus.omem_req,   0);
        check({tag, "_omem_we"},    bus.omem_we,    0);
        check({tag, "_omem_be"},    bus.omem_be,    0);
        check({tag, "_omem_addr"},  bus.omem_addr,  0);
        check({tag, "_omem_wdata"}, bus.omem_wdata, 0);
        check({tag, "_oif_rdata"},  bus.oif_rdata,  0);
        check({tag, "_od_rdata"},   bus.od_rdata,   0);
        check({tag, "_oif_valid"},  bus.oif_valid,  0);
        check({tag, "_od_valid"},   bus.od_valid,   0);
    endtask

    // Waits (bounded) until the arbiter is issuing a request.
    task automatic wait_issue(input string tag);
        int n = 0;
        while (bus.omem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_issue"}, bus.omem_req, 1);
    endtask

    // Called while omem_req is high: accept immediately, answer after rv_dly WAIT cycles.
    // Returns at the sample point of the DONE cycle.
    task automatic serve(input int rv_dly, input logic [31:0] rdata);
        bus.imem_ready = 1'b1;
        tick();
        bus.imem_ready = 1'b0;
        for (int k = 0; k < rv_dly; k++) begin
            check("wait_no_req",   bus.omem_req, 0);
            check("wait_no_valid", {bus.oif_valid, bus.od_valid}, 0);
            tick();
        end
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = rdata;
        tick();
        bus.imem_rvalid = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic        got_fetch;
        logic        exp_fetch;

        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        bus.iif_req = 1'b0;  bus.iif_addr = '0;
        bus.id_req  = 1'b0;  bus.id_we = 1'b0; bus.id_be = 2'b00;
        bus.id_addr = '0;    bus.id_wdata = '0;
        bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;

        // ---- reset state ----
        #1;
        check_all_zero("rst");
        check("rst_ostall", bus.ostall, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("idle_no_req", bus.omem_req, 0);

        // ---- single fetch, minimum latency ----
        bus.iif_req  = 1'b1;
        bus.iif_addr = 32'h100;
        tick();                                   // cycle 1: ISSUE
        check("t1_req",    bus.omem_req,  1);
        check("t1_addr",   bus.omem_addr, 32'h100);
        check("t1_we",     bus.omem_we,   0);
        check("t1_be",     bus.omem_be,   2'b10);
        check("t1_stall",  bus.ostall,    1);
        bus.imem_ready = 1'b1;
        tick();                                   // cycle 2: WAIT
        bus.imem_ready = 1'b0;
        check("t1_wait_req", bus.omem_req, 0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h00500093;
        tick();                                   // cycle 3: DONE
        bus.imem_rvalid = 1'b0;
        check("t1_valid",  bus.oif_valid, 1);
        check("t1_rdata",  bus.oif_rdata, 32'h00500093);
        check("t1_dvalid", bus.od_valid,  0);
        check("t1_stall_done", bus.ostall, 0);
        bus.iif_req = 1'b0;
        tick();
        check("t1_valid_once", bus.oif_valid, 0);
        check("t1_stall_after", bus.ostall,   0);

        // ---- data read to give od_rdata a known value ----
        bus.id_req = 1'b1; bus.id_we = 1'b0; bus.id_be = 2'b10; bus.id_addr = 32'h3000;
        tick();
        check("t2r_addr", bus.omem_addr, 32'h3000);
        serve(0, 32'h11223344);
        check("t2r_valid", bus.od_valid, 1);
        check("t2r_rdata", bus.od_rdata, 32'h11223344);
        bus.id_req = 1'b0;
        tick();

        // ---- data write, ready delayed 3 cycles, stray rvalid during ISSUE ----
        bus.id_req = 1'b1; bus.id_we = 1'b1; bus.id_be = 2'b10;
        bus.id_addr = 32'h2000; bus.id_wdata = 32'hDEADBEEF;
        tick();
        for (int c = 0; c < 4; c++) begin
            check("t2w_req",   bus.omem_req,   1);
            check("t2w_addr",  bus.omem_addr,  32'h2000);
            check("t2w_wdata", bus.omem_wdata, 32'hDEADBEEF);
            check("t2w_we",    bus.omem_we,    1);
            check("t2w_be",    bus.omem_be,    2'b10);
            bus.imem_rvalid = (c == 1);
            bus.imem_rdata  = 32'hBAD0BAD0;
            bus.imem_ready  = (c == 3);
            tick();
        end
        bus.imem_ready = 1'b0;
        check("t2w_wait_req", bus.omem_req, 0);
        check("t2w_no_early", bus.od_valid, 0);
        bus.imem_rvalid = 1'b1;
        tick();
        bus.imem_rvalid = 1'b0;
        check("t2w_valid",  bus.od_valid,  1);
        check("t2w_rdata_kept", bus.od_rdata, 32'h11223344);
        check("t2w_ifvalid", bus.oif_valid, 0);
        bus.id_req = 1'b0; bus.id_we = 1'b0;
        tick();
        check("t2w_valid_once", bus.od_valid, 0);

        // ---- simultaneous requests: data first, then fetch ----
        bus.iif_req = 1'b1; bus.iif_addr = 32'h200;
        bus.id_req  = 1'b1; bus.id_addr  = 32'h3004; bus.id_be = 2'b01;
        tick();
        check("t3_first_addr", bus.omem_addr, 32'h3004);
        check("t3_first_be",   bus.omem_be,   2'b01);
        serve(0, 32'hAAAA0001);
        check("t3_d_valid", {bus.oif_valid, bus.od_valid}, 2'b01);
        check("t3_d_rdata", bus.od_rdata, 32'hAAAA0001);
        check("t3_stall_fetch_pending", bus.ostall, 1);
        bus.id_req = 1'b0;
        tick();
        check("t3_idle_req",   bus.omem_req, 0);
        check("t3_idle_stall", bus.ostall,   1);
        tick();
        check("t3_second_addr", bus.omem_addr, 32'h200);
        check("t3_second_be",   bus.omem_be,   2'b10);
        check("t3_second_we",   bus.omem_we,   0);
        serve(1, 32'hBBBB0002);
        check("t3_i_valid", {bus.oif_valid, bus.od_valid}, 2'b10);
        check("t3_i_rdata", bus.oif_rdata, 32'hBBBB0002);
        bus.iif_req = 1'b0;
        tick();
        check("t3_no_more_valid", {bus.oif_valid, bus.od_valid}, 2'b00);
        check("t3_stall_clear",   bus.ostall, 0);

        // ---- starvation guard: D,D,D,D,I,D,D,D,D,I ----
        bus.iif_req = 1'b1; bus.iif_addr = 32'h400;
        bus.id_req  = 1'b1; bus.id_addr  = 32'h800; bus.id_be = 2'b10;
        for (int g = 0; g < 10; g++) begin
            wait_issue("t4");
            got_fetch = (bus.omem_addr == 32'h400);
            exp_fetch = (g == 4) || (g == 9);
            check($sformatf("t4_grant%0d", g), got_fetch, exp_fetch);
            serve(0, 32'h5000 + g);
            check($sformatf("t4_pulse%0d", g), {bus.oif_valid, bus.od_valid},
                  exp_fetch ? 2'b10 : 2'b01);
            if (g == 9) begin
                bus.iif_req = 1'b0;
                bus.id_req  = 1'b0;
            end
            tick();
        end
        check("t4_end_req",   bus.omem_req, 0);
        check("t4_end_stall", bus.ostall,   0);
        check("t4_last_data", bus.od_rdata, 32'h5008);

        // ---- reset during WAIT, late rvalid ignored ----
        bus.id_req = 1'b1; bus.id_we = 1'b0; bus.id_addr = 32'h3008;
        tick();
        bus.imem_ready = 1'b1;
        tick();                                   // now in WAIT
        bus.imem_ready = 1'b0;
        bus.id_req = 1'b0;
        rst = 1'b1;
        #1;
        check_all_zero("t5_rst");
        tick();
        rst = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD0005;
        tick();
        bus.imem_rvalid = 1'b0;
        check_all_zero("t5_late");
        tick();
        check("t5_no_pulse", {bus.oif_valid, bus.od_valid}, 2'b00);
        bus.iif_req = 1'b1; bus.iif_addr = 32'h104;
        tick();
        check("t5_next_req",  bus.omem_req,  1);
        check("t5_next_addr", bus.omem_addr, 32'h104);
        serve(2, 32'h00108093);
        check("t5_next_valid", bus.oif_valid, 1);
        check("t5_next_rdata", bus.oif_rdata, 32'h00108093);
        bus.iif_req = 1'b0;
        tick();

        // ---- reads with rvalid latency 0..5 against the memory model ----
        for (int i = 0; i < 6; i++) begin
            a = $urandom & 32'h0000_FFFC;
            bus.id_req = 1'b1; bus.id_we = 1'b0; bus.id_addr = a;
            tick();
            check($sformatf("t6_addr%0d", i), bus.omem_addr, a);
            serve(i, mem_model(a));
            check($sformatf("t6_valid%0d", i), bus.od_valid, 1);
            check($sformatf("t6_rdata%0d", i), bus.od_rdata, mem_model(a));
            bus.id_req = 1'b0;
            tick();
            check($sformatf("t6_once%0d", i), bus.od_valid, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
